// File: rtl/fifo_sync_param_pkg.sv
// ============================================================================
// fifo_pkg : shared width helpers and default thresholds for the FIFO family
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int c_DEF_WIDTH     = 8;
  localparam int c_DEF_DEPTH     = 16;
  localparam int c_DEF_AF_MARGIN = 2;
  localparam int c_DEF_AE_THRESH = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Pointer width is kept at least one bit so a degenerate depth still elaborates.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_param_if.sv
// ============================================================================
// fifo_sync_param_if : request/status bundle between a FIFO and its user
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int DEPTH = c_DEF_DEPTH
);

  localparam int c_CW = cnt_width(DEPTH);

  logic             clear;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [c_CW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, write, data_in, read,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, write, data_in, read,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo_sync_param_mem.sv
// ============================================================================
// fifo_mem : WIDTH x DEPTH array, synchronous write, registered read
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_re,
  input  wire logic [AW-1:0]    i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_sync_param.sv
// ============================================================================
// fifo_sync_param : single-clock FIFO with thresholds, count and error pulses
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = c_DEF_WIDTH,
  parameter int DEPTH     = c_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - c_DEF_AF_MARGIN,
  parameter int AE_THRESH = c_DEF_AE_THRESH
) (
  input wire logic        clk,
  input wire logic        reset,
  fifo_sync_param_if.slave bus
);

  localparam int c_AW = ptr_width(DEPTH);
  localparam int c_CW = cnt_width(DEPTH);

  generate
    if ((DEPTH < 2) || (AF_THRESH > DEPTH) || (AE_THRESH >= DEPTH)) begin : g_param_check
      $error("fifo_sync_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             r_data_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;

  function automatic logic [c_AW-1:0] next_ptr(input logic [c_AW-1:0] p);
    return (p == c_AW'(DEPTH - 1)) ? '0 : p + c_AW'(1);
  endfunction

  assign w_full   = (r_count == c_CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A flush masks both requests so neither memory port fires.
  assign w_rd_acc = bus.read  & ~w_empty & ~bus.clear;
  assign w_wr_acc = bus.write & (~w_full | w_rd_acc) & ~bus.clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      r_data_valid <= w_rd_acc;
      r_overflow   <= bus.write & ~w_wr_acc;
      r_underflow  <= bus.read  & ~w_rd_acc;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.data_out     = w_rdata;
  assign bus.data_valid   = r_data_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_CW'(AF_THRESH));
  assign bus.almost_empty = (r_count <= c_CW'(AE_THRESH));
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
// ============================================================================
// tb_fifo_sync_param : vector table plus data scoreboard for fifo_sync_param
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;
  localparam int CW = cnt_width(D);

  typedef struct {
    logic         clr;
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    int           cnt;
    logic         ovf;
    logic         udf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           checks = 0;
  int           errors = 0;
  vec_t         vq[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout = '0;
  logic         exp_dv   = 1'b0;

  function automatic void add(input logic clr, input logic wr, input logic rd,
                              input logic [W-1:0] din, input int cnt,
                              input logic ovf, input logic udf);
    vec_t v;
    v.clr = clr; v.wr = wr; v.rd = rd; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vq.push_back(v);
  endfunction

  // Status order: count, full, empty, almost_full, almost_empty, ovf, udf, dv
  function automatic logic [CW+6:0] status_exp(input int cnt, input logic ovf,
                                               input logic udf, input logic dv);
    return {CW'(cnt), (cnt == D), (cnt == 0), (cnt >= AF), (cnt <= AE), ovf, udf, dv};
  endfunction

  task automatic check_now(input string name, input logic [CW+6:0] exp);
    logic [CW+6:0] act;
    act = {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
           bus.overflow, bus.underflow, bus.data_valid};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s status actual=%b required=%b", name, act, exp);
    end
    checks++;
    if (bus.data_out !== exp_dout) begin
      errors++;
      $display("FAIL %s data_out actual=%h required=%h", name, bus.data_out, exp_dout);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    logic rdacc, wracc;
    @(negedge clk);
    bus.clear   = v.clr;
    bus.write   = v.wr;
    bus.read    = v.rd;
    bus.data_in = v.din;
    if (v.clr) begin
      mq.delete();
      exp_dv = 1'b0;
    end else begin
      rdacc = v.rd && (mq.size() > 0);
      wracc = v.wr && ((mq.size() < D) || rdacc);
      if (rdacc) exp_q.push_back(mq.pop_front());
      if (wracc) mq.push_back(v.din);
      exp_dv = rdacc;
    end
    @(posedge clk);
    #1;
    if (exp_dv && (exp_q.size() > 0)) exp_dout = exp_q.pop_front();
    check_now(name, status_exp(v.cnt, v.ovf, v.udf, exp_dv));
  endtask

  initial begin
    reset = 1'b1;
    bus.clear = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.data_in = '0;

    add(0,1,0,8'h11,1,0,0); add(0,1,0,8'h22,2,0,0);
    add(0,1,0,8'h33,3,0,0); add(0,1,0,8'h44,4,0,0);
    add(0,1,0,8'h55,4,1,0);
    add(0,0,1,8'h00,3,0,0); add(0,0,1,8'h00,2,0,0);
    add(0,0,1,8'h00,1,0,0); add(0,0,1,8'h00,0,0,0);
    add(0,1,0,8'hAA,1,0,0); add(0,1,0,8'hBB,2,0,0); add(0,1,0,8'hCC,3,0,0);
    add(0,0,1,8'h00,2,0,0); add(0,0,1,8'h00,1,0,0); add(0,0,1,8'h00,0,0,0);
    add(0,1,0,8'h01,1,0,0); add(0,1,0,8'h02,2,0,0);
    add(0,1,0,8'h03,3,0,0); add(0,1,0,8'h04,4,0,0);
    add(0,1,1,8'h55,4,0,0);
    add(0,0,1,8'h00,3,0,0); add(0,0,1,8'h00,2,0,0);
    add(0,0,1,8'h00,1,0,0); add(0,0,1,8'h00,0,0,0);
    add(0,1,1,8'h66,1,0,1);
    add(0,0,1,8'h00,0,0,0);
    add(0,1,0,8'h77,1,0,0); add(0,1,0,8'h88,2,0,0); add(0,1,0,8'h99,3,0,0);
    add(1,1,0,8'h5A,0,0,0);
    add(0,0,1,8'h00,0,0,1); add(0,0,1,8'h00,0,0,1); add(0,0,1,8'h00,0,0,1);
    add(0,0,0,8'h00,0,0,0);

    #12;
    check_now("reset", status_exp(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], $sformatf("vec%0d", i));
    end

    // Mid-stream async reset: three writes then reset between clock edges.
    begin
      vec_t v;
      v.clr = 0; v.wr = 1; v.rd = 0; v.ovf = 0; v.udf = 0;
      for (int k = 0; k < 3; k++) begin
        v.din = 8'hC0 + 8'(k);
        v.cnt = k + 1;
        apply(v, $sformatf("pre_rst%0d", k));
      end
      @(negedge clk);
      bus.write = 1'b0;
      #2 reset = 1'b1;
      #1;
      mq.delete();
      exp_q.delete();
      exp_dout = '0;
      exp_dv   = 1'b0;
      check_now("async_reset", status_exp(0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      v.wr = 0; v.cnt = 0; v.din = '0;
      apply(v, "post_rst_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Generalised in data width and depth; count-based full/empty.
- Adds simultaneous read+write, programmable almost-full/almost-empty thresholds, occupancy count, overflow/underflow pulses and synchronous flush.
- Sits between producer/consumer blocks in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2; need not be a power of two).
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush.
- write  in  1  write request.
- data_in  in  WIDTH  write data.
- read  in  1  read request.
- data_out  out  WIDTH  registered read data.
- data_valid  out  1  data_out updated this cycle (1-cycle pulse).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  CW  occupancy 0..DEPTH; CW = clog2(DEPTH+1).
- overflow  out  1  1-cycle pulse: write rejected.
- underflow  out  1  1-cycle pulse: read rejected.

Behaviour:
- Reset (async, active-high):
  - rd_ptr = wr_ptr = count = 0; data_out = 0; data_valid = 0; overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0 ? 1 : 0).
  - Memory contents are not reset.
- Priority: reset > clear > read/write.
- clear (sync):
  - Pointers and count go to 0; data_valid, overflow and underflow go to 0.
  - data_out holds its value; requests in the same cycle are ignored, no flags raised.
- Acceptance:
  - rd_acc = read & !empty.
  - wr_acc = write & (!full | rd_acc).
  - A write into a full FIFO succeeds only if a read is accepted in the same cycle.
- Read latency 1 cycle:
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1 at the same edge.
  - Otherwise data_valid <= 0 and data_out holds.
- Write: on wr_acc, mem[wr_ptr] <= data_in.
- Pointers:
  - Increment on acceptance.
  - Wrap from DEPTH-1 to 0 (explicit compare, not power-of-two rollover).
- count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never exceeds DEPTH or goes below 0.
- Flags full, empty, almost_full, almost_empty:
  - Combinational decodes of the registered count only.
  - They change on the same edge as count.
- Empty FIFO with read & write together:
  - The write is accepted; the read is rejected.
  - underflow pulses; no fall-through.
  - The written word is readable from the next cycle.
- Full FIFO with read & write together: both accepted, count stays DEPTH, no overflow.
- Error pulses (registered, 1 cycle per offending request, non-sticky):
  - overflow <= write & !wr_acc.
  - underflow <= read & !rd_acc.
- Reset mid-operation: immediate async clear of all state listed above; an in-flight data_valid is dropped.
- Elaboration check: AF_THRESH <= DEPTH, AE_THRESH < DEPTH, DEPTH >= 2.

Decomposition:
- Package fifo_pkg:
  - clog2 function.
  - Pointer/count width helper constants.
  - Default threshold constants, shared with future async/multi-channel FIFO variants.
- One sub-module fifo_mem:
  - WIDTH x DEPTH storage array.
  - Synchronous write port (we, waddr, wdata).
  - Registered read port (re, raddr, rdata).
- The top holds pointers, count, flag logic and error pulses.

Test Plan (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1):
- Reset then idle:
  - empty=1, full=0, almost_empty=1, almost_full=0, count=0, data_out=0x00.
  - Assert reset mid-stream after 3 writes -> same values on the next sample, no clock edge required.
- Fill and drain:
  - Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count=3; full at 4.
  - A 5th write -> overflow pulse, count stays 4.
  - 4 reads -> data_out 0x11..0x44, each one cycle after its read, with data_valid.
- Wrap-around: write 3, read 3, write 4, read 4 -> data order preserved across pointer wrap; empty=1 at end.
- Simultaneous at boundaries:
  - Full + read & write 0x55 -> count stays 4, no overflow, oldest word out.
  - Empty + read & write 0x66 -> underflow pulse, count=1; next read returns 0x66.
- clear:
  - With count=3, assert clear with write=1 -> count=0, empty=1, no overflow.
  - data_out unchanged; the write is discarded.
- Underflow: read on empty for 3 cycles -> underflow high 3 cycles, data_valid=0, data_out holds.
